// File: rtl/demux_stream.sv
// Purpose: registered 1-to-N stream demux with broadcast mode and out-of-range select drop counting.
// Latency: 1 cycle from input handshake to out_valid on the target channel(s).
// Backpressure: in_ready follows the target channel's free state (AND of all channels in broadcast); bad selects are always accepted.
//
// Ports:
//   clk, rst_n                 clock (rising edge) and asynchronous active-low reset
//   in_data/in_sel/in_valid    producer payload, destination index and request
//   in_ready                   combinational accept; depends on in_sel, bcast, out_ready and channel state only
//   bcast                      1 = deliver to every channel, 0 = route by in_sel
//   out_data/out_valid         per-channel registered payload (channel k at [k*WIDTH +: WIDTH]) and valid
//   out_ready                  per-channel consumer ready
//   sel_err                    sticky flag, set by the first out-of-range select
//   drop_cnt                   saturating count of dropped transfers
module demux_stream #(
    parameter int WIDTH = 8,
    parameter int N_CH  = 4,
    parameter int SEL_W = 2,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  bcast,
    output logic [N_CH*WIDTH-1:0] out_data,
    output logic [N_CH-1:0]       out_valid,
    input  logic [N_CH-1:0]       out_ready,
    output logic                  sel_err,
    output logic [CNT_W-1:0]      drop_cnt
);

    // One extra bit so N_CH == 2^SEL_W is representable in the range compare.
    localparam logic [SEL_W:0] NCH_L = (SEL_W + 1)'(N_CH);

    logic [N_CH-1:0]  free;
    logic [N_CH-1:0]  load;
    logic [N_CH-1:0]  valid_d;
    logic [N_CH-1:0]  valid_q;
    logic [WIDTH-1:0] data_q [N_CH];
    logic             sel_ok;
    logic             sel_free;
    logic             hs;
    logic             drop;
    logic             err_d;
    logic             err_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // A channel can take new data if empty or being drained this cycle.
    assign free   = ~valid_q | out_ready;
    assign sel_ok = ({1'b0, in_sel} < NCH_L);

    // Mux out the selected channel's free bit without indexing past N_CH.
    always_comb begin
        sel_free = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_free = free[k];
            end
        end
    end

    // in_valid deliberately absent here: no in_valid -> in_ready path.
    always_comb begin
        if (bcast) begin
            in_ready = &free;
        end else if (sel_ok) begin
            in_ready = sel_free;
        end else begin
            in_ready = 1'b1;
        end
    end

    assign hs   = in_valid & in_ready;
    assign drop = hs & ~bcast & ~sel_ok;

    always_comb begin
        load = '0;
        for (int k = 0; k < N_CH; k++) begin
            load[k] = hs & (bcast | (sel_ok & (in_sel == SEL_W'(k))));
        end
    end

    // A load wins over a drain, so back-to-back transfers keep valid high.
    assign valid_d = load | (valid_q & ~out_ready);

    always_comb begin
        err_d = err_q | drop;
        cnt_d = cnt_q;
        if (drop && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            for (int k = 0; k < N_CH; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            for (int k = 0; k < N_CH; k++) begin
                if (load[k]) begin
                    data_q[k] <= in_data;
                end
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_out
        assign out_data[g*WIDTH +: WIDTH] = data_q[g];
    end

    assign out_valid = valid_q;
    assign sel_err   = err_q;
    assign drop_cnt  = cnt_q;

endmodule
